// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK_WAIT
  } rx_state_t;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  // Parity-select encoding for PARITY_ODD.
  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

endpackage

// File: rtl/uart_rx_shift.sv
// LSB-first receive shift register with bit counter and running parity.
module uart_rx_shift #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 smp_i,
  input  logic                 bit_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 par_o,
  output logic                 done_o
);
  localparam int CW = $clog2(DATA_BITS + 1);

  logic [DATA_BITS-1:0] data_q;
  logic [CW-1:0]        cnt_q;
  logic                 par_q;

  // done marks the sample that completes the character.
  assign done_o = smp_i && (cnt_q == CW'(DATA_BITS - 1));
  assign data_o = data_q;
  assign par_o  = par_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      data_q <= '0;
      cnt_q  <= '0;
      par_q  <= 1'b0;
    end else if (smp_i) begin
      data_q <= {bit_i, data_q[DATA_BITS-1:1]};
      par_q  <= par_q ^ bit_i;
      cnt_q  <= done_o ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detection, mid-bit sampling, valid/ready
// delivery of each character with frame/parity error flags.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = PAR_EVEN
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RXC,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_VALID,
  input  logic                 RX_READY,
  output logic                 FRAME_ERR,
  output logic                 PARITY_ERR,
  output logic                 OVERRUN,
  output logic                 BUSY
);
  localparam int            TW      = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);
  localparam logic          ODD     = (PARITY_ODD != 0);

  rx_state_t            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic                 perr_q;
  logic [DATA_BITS-1:0] sh_data;
  logic                 sh_par, sh_done;
  logic                 mid, start_ok, data_smp, par_smp, stop_smp;

  assign mid      = (tick_q == FULL_M1);
  assign start_ok = RXC && (state_q == ST_START) && (tick_q == HALF_M1) && !RXD;
  assign data_smp = RXC && (state_q == ST_DATA) && mid;
  assign par_smp  = RXC && (state_q == ST_PARITY) && mid;
  assign stop_smp = RXC && (state_q == ST_STOP) && mid;

  uart_rx_shift #(.DATA_BITS(DATA_BITS)) u_shift (
    .clk_i  (CLK),
    .rst_i  (RST),
    .clr_i  (start_ok),
    .smp_i  (data_smp),
    .bit_i  (RXD),
    .data_o (sh_data),
    .par_o  (sh_par),
    .done_o (sh_done)
  );

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    if (RXC) begin
      unique case (state_q)
        ST_IDLE: begin
          tick_d = '0;
          if (!RXD) state_d = ST_START;
        end
        ST_START: begin
          if (tick_q == HALF_M1) begin
            tick_d  = '0;
            state_d = RXD ? ST_IDLE : ST_DATA;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        ST_DATA: begin
          tick_d = mid ? '0 : tick_q + TW'(1);
          if (sh_done) state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: begin
          tick_d = mid ? '0 : tick_q + TW'(1);
          if (mid) state_d = ST_STOP;
        end
        ST_STOP: begin
          tick_d = mid ? '0 : tick_q + TW'(1);
          // An all-zero frame with a low stop bit is a break; park until the line idles.
          if (mid) state_d = (!RXD && sh_data == '0) ? ST_BREAK_WAIT : ST_IDLE;
        end
        ST_BREAK_WAIT: begin
          tick_d = '0;
          if (RXD) state_d = ST_IDLE;
        end
        default: begin
          tick_d  = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      tick_q     <= '0;
      perr_q     <= 1'b0;
      RX_DATA    <= '0;
      RX_VALID   <= 1'b0;
      FRAME_ERR  <= 1'b0;
      PARITY_ERR <= 1'b0;
      OVERRUN    <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      BUSY    <= (state_d != ST_IDLE);
      OVERRUN <= 1'b0;
      if (par_smp) perr_q <= ((sh_par ^ RXD) != ODD);
      if (stop_smp) begin
        // A completion coinciding with a transfer replaces the old character.
        if (!RX_VALID || RX_READY) begin
          RX_DATA    <= sh_data;
          FRAME_ERR  <= !RXD;
          PARITY_ERR <= (PARITY_EN != 0) ? perr_q : 1'b0;
          RX_VALID   <= 1'b1;
        end else begin
          OVERRUN <= 1'b1;
        end
      end else if (RX_VALID && RX_READY) begin
        RX_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: 8N1 instance plus an even-parity instance.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
  logic       clk = 1'b0, rst = 1'b1, rxc = 1'b0;
  logic       rxd = 1'b1, rxd_p = 1'b1, rdy = 1'b1, rdy_p = 1'b1;
  logic [7:0] rx_data, rx_data_p;
  logic       rx_valid, ferr, perr, ovr, busy;
  logic       rx_valid_p, ferr_p, perr_p, ovr_p, busy_p;
  int         div = 0;
  int         pass_cnt = 0, total_cnt = 0;
  int         ovr_cnt = 0, rise_cnt = 0;
  logic       vld_prev = 1'b0;
  logic [7:0] cap_data = 8'h00;
  logic       cap_ferr = 1'b0;
  int         snap, snap_o;

  uart_rx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .CLK(clk), .RST(rst), .RXC(rxc), .RXD(rxd), .RX_DATA(rx_data), .RX_VALID(rx_valid),
    .RX_READY(rdy), .FRAME_ERR(ferr), .PARITY_ERR(perr), .OVERRUN(ovr), .BUSY(busy));

  uart_rx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .CLK(clk), .RST(rst), .RXC(rxc), .RXD(rxd_p), .RX_DATA(rx_data_p), .RX_VALID(rx_valid_p),
    .RX_READY(rdy_p), .FRAME_ERR(ferr_p), .PARITY_ERR(perr_p), .OVERRUN(ovr_p), .BUSY(busy_p));

  always #5 clk = ~clk;

  // RXC: one-cycle pulse every 4 clocks.
  always @(posedge clk) begin
    div <= (div == 3) ? 0 : div + 1;
    rxc <= (div == 3);
  end

  always @(negedge clk) begin
    vld_prev <= rx_valid;
    if (ovr) ovr_cnt <= ovr_cnt + 1;
    if (rx_valid && !vld_prev) rise_cnt <= rise_cnt + 1;
    if (rx_valid && rdy) begin
      cap_data <= rx_data;
      cap_ferr <= ferr;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Advance to #1 after the next clock edge that samples RXC=1.
  task automatic tick();
    do @(negedge clk); while (rxc !== 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input bit sel_p, input logic v);
    if (sel_p) rxd_p = v;
    else       rxd   = v;
  endtask

  // Drives start, data, optional parity, then 8 ticks of stop; the next tick samples stop.
  task automatic send_frame(input bit sel_p, input logic [7:0] d, input bit with_par,
                            input logic par_b, input logic stop_b);
    set_line(sel_p, 1'b0);
    repeat (16) tick();
    for (int i = 0; i < 8; i++) begin
      set_line(sel_p, d[i]);
      repeat (16) tick();
    end
    if (with_par) begin
      set_line(sel_p, par_b);
      repeat (16) tick();
    end
    set_line(sel_p, stop_b);
    repeat (8) tick();
  endtask

  // Stop-sample tick; optionally raises RX_READY only during that completion cycle.
  task automatic final_tick(input bit rdy_pulse);
    logic old;
    old = rdy;
    do @(negedge clk); while (rxc !== 1'b1);
    if (rdy_pulse) rdy = 1'b1;
    @(posedge clk);
    #1;
    if (rdy_pulse) rdy = old;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rx_valid); else pass_cnt++;
    total_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_data: got %h want 00", rx_data); else pass_cnt++;
    total_cnt++; if ({ferr, perr, ovr, busy} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {ferr, perr, ovr, busy}); else pass_cnt++;
    @(negedge clk) rst = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_clean();
    rdy = 1'b1;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    total_cnt++; if ({rx_valid, busy} !== 2'b01) $display("FAIL clean_pre: got valid,busy=%b want 01", {rx_valid, busy}); else pass_cnt++;
    final_tick(1'b0);
    total_cnt++; if (rx_valid !== 1'b1) $display("FAIL clean_valid: got %b want 1", rx_valid); else pass_cnt++;
    total_cnt++; if (rx_data !== 8'hA5) $display("FAIL clean_data: got %h want a5", rx_data); else pass_cnt++;
    total_cnt++; if ({ferr, perr, busy} !== 3'b000) $display("FAIL clean_flags: got ferr,perr,busy=%b want 000", {ferr, perr, busy}); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (rx_valid !== 1'b0) $display("FAIL clean_pulse: got %b want 0", rx_valid); else pass_cnt++;
    rxd = 1'b1;
    repeat (16) tick();
  endtask

  task automatic test_false_start();
    snap = rise_cnt;
    rxd = 1'b0;
    repeat (5) tick();
    total_cnt++; if (busy !== 1'b1) $display("FAIL false_busy_hi: got %b want 1", busy); else pass_cnt++;
    rxd = 1'b1;
    repeat (3) tick();
    total_cnt++; if (busy !== 1'b1) $display("FAIL false_busy_hold: got %b want 1", busy); else pass_cnt++;
    tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL false_busy_lo: got %b want 0", busy); else pass_cnt++;
    repeat (16) tick();
    total_cnt++; if (rise_cnt !== snap) $display("FAIL false_novalid: got %0d want %0d", rise_cnt, snap); else pass_cnt++;
  endtask

  task automatic test_parity();
    rdy_p = 1'b1;
    send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
    final_tick(1'b0);
    total_cnt++; if ({rx_valid_p, rx_data_p} !== {1'b1, 8'h03}) $display("FAIL par1_data: got %b/%h want 1/03", rx_valid_p, rx_data_p); else pass_cnt++;
    total_cnt++; if ({perr_p, ferr_p} !== 2'b10) $display("FAIL par1_err: got perr,ferr=%b want 10", {perr_p, ferr_p}); else pass_cnt++;
    repeat (16) tick();
    send_frame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
    final_tick(1'b0);
    total_cnt++; if ({rx_valid_p, rx_data_p} !== {1'b1, 8'h03}) $display("FAIL par0_data: got %b/%h want 1/03", rx_valid_p, rx_data_p); else pass_cnt++;
    total_cnt++; if (perr_p !== 1'b0) $display("FAIL par0_err: got %b want 0", perr_p); else pass_cnt++;
    repeat (16) tick();
  endtask

  task automatic test_frame_err();
    rdy = 1'b1;
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
    final_tick(1'b0);
    total_cnt++; if ({rx_valid, rx_data} !== {1'b1, 8'h55}) $display("FAIL ferr_data: got %b/%h want 1/55", rx_valid, rx_data); else pass_cnt++;
    total_cnt++; if ({ferr, busy} !== 2'b10) $display("FAIL ferr_flag: got ferr,busy=%b want 10", {ferr, busy}); else pass_cnt++;
    rxd = 1'b1;
    repeat (16) tick();
  endtask

  task automatic test_break();
    rdy = 1'b1;
    snap = rise_cnt;
    rxd = 1'b0;
    repeat (480) tick();
    total_cnt++; if (busy !== 1'b1) $display("FAIL break_wait: got busy %b want 1", busy); else pass_cnt++;
    total_cnt++; if (rise_cnt - snap !== 1) $display("FAIL break_count: got %0d want 1", rise_cnt - snap); else pass_cnt++;
    total_cnt++; if ({cap_data, cap_ferr} !== {8'h00, 1'b1}) $display("FAIL break_char: got %h/%b want 00/1", cap_data, cap_ferr); else pass_cnt++;
    rxd = 1'b1;
    tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL break_exit: got busy %b want 0", busy); else pass_cnt++;
    repeat (20) tick();
    total_cnt++; if (rise_cnt - snap !== 1) $display("FAIL break_once: got %0d want 1", rise_cnt - snap); else pass_cnt++;
  endtask

  task automatic test_overrun();
    rdy = 1'b0;
    snap_o = ovr_cnt;
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    final_tick(1'b0);
    total_cnt++; if ({rx_valid, rx_data} !== {1'b1, 8'h11}) $display("FAIL ovr_first: got %b/%h want 1/11", rx_valid, rx_data); else pass_cnt++;
    repeat (16) tick();
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    final_tick(1'b0);
    total_cnt++; if (ovr !== 1'b1) $display("FAIL ovr_pulse: got %b want 1", ovr); else pass_cnt++;
    total_cnt++; if ({rx_valid, rx_data} !== {1'b1, 8'h11}) $display("FAIL ovr_keep: got %b/%h want 1/11", rx_valid, rx_data); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (ovr !== 1'b0) $display("FAIL ovr_width: got %b want 0", ovr); else pass_cnt++;
    repeat (16) tick();
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    final_tick(1'b1);
    total_cnt++; if ({rx_valid, rx_data, ovr} !== {1'b1, 8'h22, 1'b0}) $display("FAIL ovr_ready: got %b/%h/%b want 1/22/0", rx_valid, rx_data, ovr); else pass_cnt++;
    total_cnt++; if (ovr_cnt - snap_o !== 1) $display("FAIL ovr_count: got %0d want 1", ovr_cnt - snap_o); else pass_cnt++;
    @(negedge clk) rdy = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (rx_valid !== 1'b0) $display("FAIL ovr_drain: got %b want 0", rx_valid); else pass_cnt++;
    rdy = 1'b0;
    repeat (16) tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    rdy = 1'b0;
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    final_tick(1'b0);
    rxd = 1'b1;
    repeat (16) tick();
    d = 8'h3C;
    rxd = 1'b0;
    repeat (16) tick();
    for (int i = 0; i < 3; i++) begin
      rxd = d[i];
      repeat (16) tick();
    end
    rxd = d[3];
    repeat (8) tick();
    total_cnt++; if ({rx_valid, busy} !== 2'b11) $display("FAIL rmid_pre: got valid,busy=%b want 11", {rx_valid, busy}); else pass_cnt++;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if ({rx_valid, rx_data} !== 9'h000) $display("FAIL rmid_out: got %b/%h want 0/00", rx_valid, rx_data); else pass_cnt++;
    total_cnt++; if ({ferr, perr, ovr, busy} !== 4'b0) $display("FAIL rmid_flags: got %b want 0000", {ferr, perr, ovr, busy}); else pass_cnt++;
    @(negedge clk) rst = 1'b0;
    rxd = 1'b1;
    repeat (40) tick();
    rdy = 1'b1;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    final_tick(1'b0);
    total_cnt++; if ({rx_valid, rx_data, ferr} !== {1'b1, 8'h3C, 1'b0}) $display("FAIL rmid_after: got %b/%h/%b want 1/3c/0", rx_valid, rx_data, ferr); else pass_cnt++;
    rxd = 1'b1;
    repeat (8) tick();
  endtask

  initial begin
    test_reset();
    test_clean();
    test_false_start();
    test_parity();
    test_frame_err();
    test_break();
    test_overrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive controller that sequences the serial receive datapath. It consumes the glitch-filtered serial line and the oversampling enable `RXC`, finds start bits, and samples data, optional parity and stop bits at mid-bit. Each received character goes to the host over a valid/ready handshake, together with error flags. It sits between the upstream input glitch filter and the receive FIFO / register interface.

## Interface
- `DATA_BITS`, default 8: data bits per character (5..8), sent LSB first.
- `OVERSAMPLE`, default 16: `RXC` ticks per bit period (even, ≥4).
- `PARITY_EN`, default 0: 1 adds a parity bit after the data bits.
- `PARITY_ODD`, default 0: 1 selects odd parity, 0 selects even (used only when `PARITY_EN`=1).
- `CLK` in 1: single system clock, rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `RXC` in 1: oversampling enable, one-`CLK`-wide pulse, `OVERSAMPLE` pulses per bit.
- `RXD` in 1: filtered serial line, idle high.
- `RX_DATA` out `DATA_BITS`: received character, right-aligned.
- `RX_VALID` out 1: `RX_DATA` and the error flags are valid.
- `RX_READY` in 1: host accepts the character.
- `FRAME_ERR` out 1: stop bit sampled low; qualified by `RX_VALID`.
- `PARITY_ERR` out 1: parity mismatch; qualified by `RX_VALID`.
- `OVERRUN` out 1: one-cycle pulse when a completed character is dropped.
- `BUSY` out 1: high whenever the state is not IDLE.

## Operation
- **States:** IDLE, START, DATA, PARITY, STOP, BREAK_WAIT. The state machine and the tick/bit counters advance only on cycles with `RXC`=1. All other cycles hold.
- **IDLE:** on a tick with `RXD`=0, go to START and clear the tick counter.
- **START:** on the tick where the tick counter = `OVERSAMPLE`/2−1, re-check `RXD`.
  - `RXD`=1: false start, return to IDLE.
  - `RXD`=0: clear the tick counter and go to DATA.
- **DATA:** on every tick where the tick counter = `OVERSAMPLE`−1, sample `RXD` into the shift register, LSB first. After `DATA_BITS` samples, go to PARITY if `PARITY_EN`=1, otherwise go to STOP.
- **PARITY:** sample one bit at mid-bit. `PARITY_ERR` = (XOR of data bits ^ sampled parity bit) != `PARITY_ODD`.
- **STOP:** sample at mid-bit, then the character completes.
  - `RXD`=0: set `FRAME_ERR`. If the data bits were also all zero (break), go to BREAK_WAIT; otherwise go to IDLE.
  - `RXD`=1: go to IDLE.
- **BREAK_WAIT:** return to IDLE on the first tick with `RXD`=1. This stops a held-low line from being re-detected as a start bit.
- **Completion:**
  - `RX_VALID`=0: load `RX_DATA`, `FRAME_ERR` and `PARITY_ERR`, and set `RX_VALID`.
  - `RX_VALID`=1 with `RX_READY`=0: keep the old character and flags and pulse `OVERRUN` for one cycle.
  - `RX_VALID`=1 with `RX_READY`=1 in the completion cycle: load the new character, keep `RX_VALID`=1, no overrun.
- **Handshake:** the character transfers on a cycle where `RX_VALID` and `RX_READY` are both 1. With no new completion in that cycle, `RX_VALID` clears on the next edge. `RX_DATA` and the flags hold while `RX_VALID`=1.
- When `PARITY_EN`=0, `PARITY_ERR` is tied to 0.

## Timing
- **Reset:** `RST` wins over everything, including mid-frame. On reset:
  - state = IDLE and all counters = 0;
  - `RX_DATA`=0, `RX_VALID`=0, `FRAME_ERR`=0, `PARITY_ERR`=0, `OVERRUN`=0, `BUSY`=0.
- **Start qualification:** (`OVERSAMPLE`/2) ticks after the first low sample.
- **Sample points:** every later bit is sampled exactly `OVERSAMPLE` ticks after the previous sample point.
- **Output latency:** `RX_VALID` rises on the `CLK` edge that follows the `RXC` tick sampling the stop bit, i.e. one-cycle registered latency. `OVERRUN` pulses in that same cycle.
- **Back-to-back characters:** a new start bit can be detected on the first tick after STOP. There is no dead time.
- **`BUSY`:** registered; rises on the edge that leaves IDLE and falls on the edge that enters IDLE.

## Structure
- **Package `uart_pkg`:** state enum `rx_state_t`, default constants for `OVERSAMPLE` and `DATA_BITS`, and the parity-select encoding.
- **Sub-module `uart_rx_shift`:** `DATA_BITS` shift register, bit counter and running parity XOR, with sample-enable, clear and done outputs. The controller instantiates it once.
- The tick counter and the output/handshake register stay in the top level.
- The glitch filter is instantiated by the parent, not inside this block.

## Test plan
All scenarios use `OVERSAMPLE`=16 and `RXC` every 4 `CLK` cycles.
- **Clean character:** frame 0xA5 (8N1) with `RX_READY` held 1 → `RX_VALID` pulses for 1 cycle with `RX_DATA`=0xA5 and both error flags 0, one cycle after the stop-bit tick.
- **False start:** hold `RXD` low for 5 ticks, then high → `BUSY` returns to 0, no `RX_VALID`.
- **Parity:** `PARITY_EN`=1, `PARITY_ODD`=0, send 0x03 with parity bit 1 → `RX_DATA`=0x03 with `PARITY_ERR`=1. Repeat with parity bit 0 → `PARITY_ERR`=0.
- **Framing and break:**
  - Send 0x55 with the stop bit low → `FRAME_ERR`=1 and the data is delivered.
  - Send a break (line low for 30 bit periods) → exactly one character 0x00 with `FRAME_ERR`=1, then BREAK_WAIT until `RXD` goes high.
- **Overrun:** send 0x11, then 0x22, with `RX_READY`=0 → `OVERRUN` pulses once at the end of 0x22 and `RX_DATA` stays 0x11. Repeat with `RX_READY`=1 in the completion cycle → no overrun and `RX_DATA`=0x22.
- **Reset mid-frame:** assert `RST` for 1 cycle during data bit 3 → all outputs 0 and state IDLE on the next edge. A following clean 0x3C frame is received correctly.
